// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared encodings, FSM states and alignment check for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic lsu_access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11)
            || ((size == SZ_HALF) && addr_lo[0])
            || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master_if
// Brief    : Word-only mem_ctl data port; master = LSU, slave = mem_ctl.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_master_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Sub-word load extraction/extension and store merge into a word.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = rword[{addr_lo, 3'b000} +: 8];
        w_half    = rword[{addr_lo[1], 4'b0000} +: 16];
        load_data = rword;
        merged    = rword;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{w_byte[7] & ~is_unsigned}}, w_byte};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{w_half[15] & ~is_unsigned}}, w_half};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rword;
                merged    = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Brief    : Byte/half/word load-store initiator for mem_ctl, RMW for sub-word
//            stores. Option LSU_TIMEOUT_EN adds a per-phase mem_ready timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    lsu_mem_master_if.master mem
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        armed_q, armed_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;

    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_done;
    logic        w_timeout;

    lsu_lane_align u_align (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rword       (mem.mem_rdata),
        .wdata       (wdata_q),
        .load_data   (w_load),
        .merged      (w_merged)
    );

    // The first edge after a strobe rises is skipped so a ready left over
    // from the previous phase cannot complete the new one.
    assign w_done = armed_q && mem.mem_ready;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (((state_q == RD) || (state_q == WR)) && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        armed_d      = armed_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        mem_re_d     = mem_re_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_lo_d   = req_addr[1:0];
                    size_d      = req_size;
                    we_d        = req_we;
                    uns_d       = req_unsigned;
                    wdata_d     = req_wdata;
                    armed_d     = 1'b0;
                    req_ready_d = 1'b0;
                    if (lsu_access_err(req_size, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we && (req_size == SZ_WORD)) begin
                            state_d     = WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d  = RD;
                            mem_re_d = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (w_done) begin
                    mem_re_d = 1'b0;
                    armed_d  = 1'b0;
                    if (we_q) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = w_merged;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = w_load;
                    end
                end else if (w_timeout) begin
                    mem_re_d     = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    armed_d = 1'b1;
                end
            end
            WR: begin
                if (w_done || w_timeout) begin
                    mem_we_d     = 1'b0;
                    armed_d      = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !w_done;
                end else begin
                    armed_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            armed_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            armed_q      <= armed_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_re    = mem_re_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_master
// Brief    : Directed self-checking bench for lsu_mem_master with a mem_ctl model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    // mem_ctl model: ready after stall_cycles+1 edges of an asserted strobe
    logic [31:0] mem_arr [0:15];
    int          stall_cycles;
    logic        ready_always;
    int          busy_cnt;
    int          re_phases;
    int          we_phases;
    int          re_run;
    int          last_re_len;
    int          resp_cnt;
    logic        prev_re;
    logic        prev_we;
    logic        both_seen;
    logic [31:0] last_wdata;

    assign bus.mem_ready = ready_always ||
                           ((bus.mem_re || bus.mem_we) && (busy_cnt >= stall_cycles + 1));
    assign bus.mem_rdata = mem_arr[bus.mem_addr[5:2]];

    initial begin
        busy_cnt = 0; re_phases = 0; we_phases = 0; re_run = 0; last_re_len = 0;
        prev_re = 1'b0; prev_we = 1'b0; both_seen = 1'b0; last_wdata = 32'h0;
    end

    always @(posedge clk) begin
        if (!(bus.mem_re || bus.mem_we) || bus.mem_ready) busy_cnt <= 0;
        else                                              busy_cnt <= busy_cnt + 1;
        if (bus.mem_we && bus.mem_ready) begin
            mem_arr[bus.mem_addr[5:2]] <= bus.mem_wdata;
            last_wdata                 <= bus.mem_wdata;
        end
        if (bus.mem_re && !prev_re) re_phases <= re_phases + 1;
        if (bus.mem_we && !prev_we) we_phases <= we_phases + 1;
        if (bus.mem_re && bus.mem_we) both_seen <= 1'b1;
        if (bus.mem_re) re_run <= re_run + 1;
        else if (re_run != 0) begin
            last_re_len <= re_run;
            re_run      <= 0;
        end
        prev_re <= bus.mem_re;
        prev_we <= bus.mem_we;
    end

    initial resp_cnt = 0;
    always @(negedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    endtask

    int re0;
    int we0;
    int rc0;
    int n;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        stall_cycles = 0; ready_always = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_re", {31'h0, bus.mem_re}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;

        // Word store then word load
        access("sw_2000", 1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        check("sw_we_phases", 32'(we_phases), 32'd1);
        check("sw_re_phases", 32'(re_phases), 32'd0);
        access("lw_2000", 1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        check("lw_re_phases", 32'(re_phases), 32'd1);

        access("sw_2004", 1'b1, 2'b10, 1'b0, 32'h2004, 32'h11223344, 32'h0, 1'b0, 3);
        access("sw_2008", 1'b1, 2'b10, 1'b0, 32'h2008, 32'h8000FF80, 32'h0, 1'b0, 3);

        // Sub-word store: read-modify-write
        re0 = re_phases; we0 = we_phases;
        access("sb_2006", 1'b1, 2'b00, 1'b0, 32'h2006, 32'h000000AA, 32'h0, 1'b0, 5);
        check("sb_wdata", last_wdata, 32'h11AA3344);
        check("sb_re_phase", 32'(re_phases - re0), 32'd1);
        check("sb_we_phase", 32'(we_phases - we0), 32'd1);
        access("lw_2004", 1'b0, 2'b10, 1'b0, 32'h2004, 32'h0, 32'h11AA3344, 1'b0, 3);

        // Load extraction and extension
        access("lb_2008",  1'b0, 2'b00, 1'b0, 32'h2008, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        access("lbu_2008", 1'b0, 2'b00, 1'b1, 32'h2008, 32'h0, 32'h00000080, 1'b0, 3);
        access("lh_200a",  1'b0, 2'b01, 1'b0, 32'h200A, 32'h0, 32'hFFFF8000, 1'b0, 3);
        access("lhu_200a", 1'b0, 2'b01, 1'b1, 32'h200A, 32'h0, 32'h00008000, 1'b0, 3);
        access("lbu_2009", 1'b0, 2'b00, 1'b1, 32'h2009, 32'h0, 32'h000000FF, 1'b0, 3);
        access("lb_200b",  1'b0, 2'b00, 1'b0, 32'h200B, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        access("lh_2008",  1'b0, 2'b01, 1'b0, 32'h2008, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        access("lwu_2008", 1'b0, 2'b10, 1'b1, 32'h2008, 32'h0, 32'h8000FF80, 1'b0, 3);

        // Half and byte merges with junk in unused wdata bits
        access("sh_200a", 1'b1, 2'b01, 1'b0, 32'h200A, 32'hABCD1234, 32'h0, 1'b0, 5);
        access("sb_2008", 1'b1, 2'b00, 1'b0, 32'h2008, 32'hFFFFFF11, 32'h0, 1'b0, 5);
        access("lw_2008", 1'b0, 2'b10, 1'b0, 32'h2008, 32'h0, 32'h1234FF11, 1'b0, 3);

        // Illegal accesses: no bus activity
        re0 = re_phases; we0 = we_phases;
        access("lh_2001", 1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, 32'h0, 1'b1, 1);
        access("lw_2002", 1'b0, 2'b10, 1'b0, 32'h2002, 32'h0, 32'h0, 1'b1, 1);
        access("ill_size", 1'b0, 2'b11, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 1);
        access("sw_2003", 1'b1, 2'b10, 1'b0, 32'h2003, 32'h12345678, 32'h0, 1'b1, 1);
        check("err_no_re", 32'(re_phases - re0), 32'd0);
        check("err_no_we", 32'(we_phases - we0), 32'd0);

        // Ready already high when the strobe rises
        ready_always = 1'b1;
        access("lw_stale", 1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        ready_always = 1'b0;

`ifdef LSU_TIMEOUT_EN
        stall_cycles = 20;
        re0 = re_phases; we0 = we_phases;
        access("sb_timeout", 1'b1, 2'b00, 1'b0, 32'h2004, 32'h000000BB, 32'h0, 1'b1, 9);
        check("to_re_len", 32'(last_re_len), 32'd8);
        check("to_re_phase", 32'(re_phases - re0), 32'd1);
        check("to_no_we", 32'(we_phases - we0), 32'd0);
        stall_cycles = 0;
        access("lw_after_to", 1'b0, 2'b10, 1'b0, 32'h2004, 32'h0, 32'h11AA3344, 1'b0, 3);
`else
        stall_cycles = 10;
        re0 = re_phases; rc0 = resp_cnt;
        access("lw_stall", 1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 1'b0, 13);
        check("stall_re_len", 32'(last_re_len), 32'd12);
        check("stall_re_phase", 32'(re_phases - re0), 32'd1);
        check("stall_one_resp", 32'(resp_cnt - rc0), 32'd1);
        stall_cycles = 0;
`endif

        // Reset while the write half of an RMW is pending
        stall_cycles = 3;
        rc0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h2005; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!bus.mem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rmw_we_seen", {31'h0, bus.mem_we}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_we", {31'h0, bus.mem_we}, 32'h0);
        check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
        check("rmw_rst_resp", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        stall_cycles = 0;
        repeat (2) @(negedge clk);
        check("rmw_no_resp", 32'(resp_cnt - rc0), 32'd0);
        access("lw_post_rst", 1'b0, 2'b10, 1'b0, 32'h2004, 32'h0, 32'h11AA3344, 1'b0, 3);

        check("never_re_and_we", {31'h0, both_seen}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
